multicycle_controller: RTL and testbench

Sequencing FSM for the multicycle RV32I datapath, built on the same decode as the single-cycle control unit (op, funct3, funct7 bit 5, zero). It steps each instruction through fetch, decode, execute, memory and writeback, driving one shared ALU and one shared instruction/data memory port. A req/ready handshake lets memory stall any access.

---
 rtl/mc_pkg.sv | 86 ++++++++
 rtl/multicycle_controller_if.sv | 15 +
 rtl/mc_alu_decoder.sv | 39 +++
 rtl/multicycle_controller.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle RV32I controller.
// Holds the opcode constants, the FSM state codes, the control-field
// encodings (ALU, immediate, ALU source A/B, result select) and the
// immediate-format decode helper used by the controller.
`timescale 1ns/1ps
package mc_pkg;

  // RV32I major opcodes (instruction[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // FSM state codes
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMREAD  = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWRITE = 4'd5;
  localparam state_t S_EXECR    = 4'd6;
  localparam state_t S_EXECI    = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;
  localparam state_t S_JAL      = 4'd10;
  localparam state_t S_LUI      = 4'd11;
  localparam state_t S_TRAP     = 4'd12;
  localparam state_t S_IDLE     = 4'd13;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  // ALU operation class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // ALU operand selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Result bus selects
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate format is a pure function of the opcode; I-format covers
  // loads, OP-IMM and everything that does not use an immediate.
  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_sel = IMM_S;
      OP_BRANCH: imm_sel = IMM_B;
      OP_JAL:    imm_sel = IMM_J;
      OP_LUI:    imm_sel = IMM_U;
      default:   imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: shared instruction/data memory port handshake.
//   memReq    controller -> memory  access request, held until memReady
//   memWrite  controller -> memory  store strobe, meaningful only with memReq
//   adrSrc    controller -> datapath address select (0 = PC, 1 = aluOut)
//   memReady  memory -> controller  access completes this cycle
`timescale 1ns/1ps
interface multicycle_controller_if;
  logic memReq;
  logic memWrite;
  logic adrSrc;
  logic memReady;

  modport master (output memReq, output memWrite, output adrSrc, input memReady);
  modport slave  (input memReq, input memWrite, input adrSrc, output memReady);
endinterface

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: combinational ALU control decode.
//   i_isRtype     1 when the instruction is register-register (enables SUB)
//   i_funct3      instruction[14:12]
//   i_funct7b5    instruction[30]
//   i_aluOpClass  ADD, SUB, or decode-from-funct fields
//   o_aluControl  4-bit ALU operation code
`timescale 1ns/1ps
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic       i_isRtype,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic [1:0] i_aluOpClass,
  output logic [3:0] o_aluControl
);

  always_comb begin
    o_aluControl = ALU_ADD;
    case (i_aluOpClass)
      ALUOP_SUB: o_aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // funct7b5 on an I-type ADDI is immediate bit 10, so SUB is R-only
          3'b000:  o_aluControl = (i_isRtype && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_aluControl = ALU_SLL;
          3'b010:  o_aluControl = ALU_SLT;
          3'b011:  o_aluControl = ALU_SLTU;
          3'b100:  o_aluControl = ALU_XOR;
          3'b101:  o_aluControl = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_aluControl = ALU_OR;
          default: o_aluControl = ALU_AND;
        endcase
      end
      default: o_aluControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM for the multicycle RV32I datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback,
// driving one shared ALU and one shared memory port (stallable via memReady).
//
// Parameter RESET_STATE_FETCH: 1 = leave reset in FETCH, 0 = via IDLE.
// Build option MC_TRAP_EN: when defined, illegal opcodes, illegal branch
// funct3 and ECALL park the FSM in TRAP (trap = 1) until reset; otherwise
// they retire as NOPs from DECODE and trap is tied low.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   op, funct3, funct7b5          instruction fields from the IR
//   zero                          ALU zero flag (same cycle)
//   mem (master)                  memReq/memWrite/adrSrc out, memReady in
//   irWrite, pcWrite, regWrite    datapath write enables
//   resultSrc, aluSrcA, aluSrcB   datapath mux selects
//   aluControl, immSrc            ALU operation, immediate format
//   instrDone                     pulse in the last cycle of an instruction
//   trap                          illegal-instruction flag
`timescale 1ns/1ps
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int RESET_STATE_FETCH = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  multicycle_controller_if.master mem,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [3:0] aluControl,
  output logic [2:0] immSrc,
  output logic       instrDone,
  output logic       trap
);

  localparam state_t S_RESET = (RESET_STATE_FETCH != 0) ? S_FETCH : S_IDLE;
`ifdef MC_TRAP_EN
  localparam state_t S_ILLEGAL = S_TRAP;
`else
  localparam state_t S_ILLEGAL = S_FETCH;
`endif

  state_t     r_state;
  state_t     w_next;
  logic       w_branch_ok;
  logic [1:0] w_aluOpClass;
  logic       w_memReq, w_memWrite, w_irWrite, w_pcWrite, w_regWrite, w_instrDone;
`ifdef MC_TRAP_EN
  logic       w_trap;
`endif

  // Only BEQ (000) and BNE (001) are implemented.
  assign w_branch_ok = (funct3[2:1] == 2'b00);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = S_FETCH;
      S_FETCH:    if (mem.memReady) w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECR;
          OP_I:              w_next = S_EXECI;
          OP_BRANCH:         w_next = w_branch_ok ? S_BRANCH : S_ILLEGAL;
          OP_JAL:            w_next = S_JAL;
          OP_LUI:            w_next = S_LUI;
          OP_FENCE:          w_next = S_FETCH;
          OP_SYSTEM:         w_next = S_ILLEGAL;
          default:           w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   w_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem.memReady) w_next = S_MEMWB;
      S_MEMWRITE: if (mem.memReady) w_next = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH:         w_next = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_LUI:     w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RESET;
    else       r_state <= w_next;
  end

  always_comb begin
    w_memReq     = 1'b0;
    w_memWrite   = 1'b0;
    w_irWrite    = 1'b0;
    w_pcWrite    = 1'b0;
    w_regWrite   = 1'b0;
    w_instrDone  = 1'b0;
    mem.adrSrc   = 1'b0;
    resultSrc    = RES_ALUOUT;
    aluSrcA      = SRCA_PC;
    aluSrcB      = SRCB_RD2;
    w_aluOpClass = ALUOP_ADD;
`ifdef MC_TRAP_EN
    w_trap       = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        w_memReq  = 1'b1;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALURESULT;
        w_irWrite = mem.memReady;
        w_pcWrite = mem.memReady;
      end
      S_DECODE: begin
        aluSrcA     = SRCA_OLDPC;
        aluSrcB     = SRCB_IMM;
        // FENCE (and illegal ops when trapping is off) retire here
        w_instrDone = (w_next == S_FETCH);
      end
      S_MEMADR: begin
        aluSrcA = SRCA_RD1;
        aluSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        w_memReq   = 1'b1;
        mem.adrSrc = 1'b1;
      end
      S_MEMWB: begin
        resultSrc   = RES_MEMDATA;
        w_regWrite  = 1'b1;
        w_instrDone = 1'b1;
      end
      S_MEMWRITE: begin
        w_memReq    = 1'b1;
        w_memWrite  = 1'b1;
        mem.adrSrc  = 1'b1;
        w_instrDone = mem.memReady;
      end
      S_EXECR: begin
        aluSrcA      = SRCA_RD1;
        aluSrcB      = SRCB_RD2;
        w_aluOpClass = ALUOP_FUNCT;
      end
      S_EXECI: begin
        aluSrcA      = SRCA_RD1;
        aluSrcB      = SRCB_IMM;
        w_aluOpClass = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        resultSrc   = RES_ALUOUT;
        w_regWrite  = 1'b1;
        w_instrDone = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA      = SRCA_RD1;
        aluSrcB      = SRCB_RD2;
        w_aluOpClass = ALUOP_SUB;
        // funct3[0] distinguishes BNE from BEQ
        w_pcWrite    = zero ^ funct3[0];
        w_instrDone  = 1'b1;
      end
      S_JAL: begin
        aluSrcA   = SRCA_OLDPC;
        aluSrcB   = SRCB_FOUR;
        w_pcWrite = 1'b1;
      end
      S_LUI: begin
        aluSrcA = SRCA_ZERO;
        aluSrcB = SRCB_IMM;
      end
`ifdef MC_TRAP_EN
      S_TRAP: w_trap = 1'b1;
`endif
      default: ;
    endcase
  end

  // While reset is held the memory port goes idle and nothing is written,
  // so an in-flight store is abandoned as soon as reset is seen.
  assign mem.memReq   = w_memReq & ~reset;
  assign mem.memWrite = w_memWrite & ~reset;
  assign irWrite      = w_irWrite & ~reset;
  assign pcWrite      = w_pcWrite & ~reset;
  assign regWrite     = w_regWrite & ~reset;
  assign instrDone    = w_instrDone & ~reset;
`ifdef MC_TRAP_EN
  assign trap         = w_trap & ~reset;
`else
  assign trap         = 1'b0;
`endif

  assign immSrc = imm_sel(op);

  mc_alu_decoder u_alu_dec (
    .i_isRtype    (r_state == S_EXECR),
    .i_funct3     (funct3),
    .i_funct7b5   (funct7b5),
    .i_aluOpClass (w_aluOpClass),
    .o_aluControl (aluControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: each instruction is expanded into the
// list of steps it must take, and every cycle the DUT outputs are compared
// with the values those steps require. Directed cases pin latencies and
// key control values with literals; a randomized stream follows.
`timescale 1ns/1ps
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero;
  logic       irWrite, pcWrite, regWrite, instrDone, trap;
  logic [1:0] resultSrc, aluSrcA, aluSrcB;
  logic [3:0] aluControl;
  logic [2:0] immSrc;

  multicycle_controller_if mem_if();

  multicycle_controller #(.RESET_STATE_FETCH(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem(mem_if), .irWrite(irWrite), .pcWrite(pcWrite),
    .regWrite(regWrite), .resultSrc(resultSrc), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .aluControl(aluControl), .immSrc(immSrc),
    .instrDone(instrDone), .trap(trap)
  );

  always #5 clk = ~clk;

  // Step kinds an instruction walks through
  localparam int K_F = 0, K_D = 1, K_ADR = 2, K_RD = 3, K_MWB = 4, K_WR = 5;
  localparam int K_XR = 6, K_XI = 7, K_AWB = 8, K_BR = 9, K_JAL = 10, K_LUI = 11, K_TRAP = 12;

  typedef struct packed {
    logic memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, instrDone, trap;
    logic cAdr, cA, cB, cAlu, cRes, cImm;
    logic [1:0] res, srcA, srcB;
    logic [3:0] alu;
    logic [2:0] imm;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;
  int steps[$];
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;
  logic [3:0] seen_alu;
  logic       seen_pcw;
  logic [2:0] seen_imm;
  logic [1:0] seen_srcA;
  logic [1:0] seen_res;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_mem(input int k);
    return (k == K_F) || (k == K_RD) || (k == K_WR);
  endfunction

  // {care, format}
  function automatic logic [3:0] exp_imm(input logic [6:0] o);
    case (o)
      7'b0000011, 7'b0010011: return 4'b1000;
      7'b0100011:             return 4'b1001;
      7'b1100011:             return 4'b1010;
      7'b1101111:             return 4'b1011;
      7'b0110111:             return 4'b1100;
      default:                return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] ref_alu(input bit isR, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (isR && f7) ? 4'b0001 : 4'b0000;
      3'd1:    return 4'b0111;
      3'd2:    return 4'b0101;
      3'd3:    return 4'b0110;
      3'd4:    return 4'b0100;
      3'd5:    return f7 ? 4'b1001 : 4'b1000;
      3'd6:    return 4'b0011;
      default: return 4'b0010;
    endcase
  endfunction

  // Expand the current instruction into the steps it must take.
  task automatic plan();
    bit illegal;
    illegal = 1'b0;
    steps = {};
    steps.push_back(K_F);
    steps.push_back(K_D);
    case (cur_op)
      7'b0000011: begin steps.push_back(K_ADR); steps.push_back(K_RD); steps.push_back(K_MWB); end
      7'b0100011: begin steps.push_back(K_ADR); steps.push_back(K_WR); end
      7'b0110011: begin steps.push_back(K_XR); steps.push_back(K_AWB); end
      7'b0010011: begin steps.push_back(K_XI); steps.push_back(K_AWB); end
      7'b1100011: if (cur_f3 == 3'd0 || cur_f3 == 3'd1) steps.push_back(K_BR); else illegal = 1'b1;
      7'b1101111: begin steps.push_back(K_JAL); steps.push_back(K_AWB); end
      7'b0110111: begin steps.push_back(K_LUI); steps.push_back(K_AWB); end
      7'b0001111: ;
      default:    illegal = 1'b1;
    endcase
`ifdef MC_TRAP_EN
    if (illegal) steps.push_back(K_TRAP);
`else
    if (illegal) steps = steps;
`endif
  endtask

  function automatic exp_t expect_step(input int k, input bit last, input logic rdy, input logic z);
    exp_t e;
    logic [3:0] im;
    e = '0;
    im = exp_imm(cur_op);
    e.cImm = im[3];
    e.imm  = im[2:0];
    case (k)
      K_F:    begin e.memReq = 1; e.cAdr = 1; e.cA = 1; e.cB = 1; e.srcB = 2'b10; e.cAlu = 1;
                    e.cRes = 1; e.res = 2'b10; e.irWrite = rdy; e.pcWrite = rdy; end
      K_D:    begin e.cA = 1; e.srcA = 2'b01; e.cB = 1; e.srcB = 2'b01; e.cAlu = 1; end
      K_ADR:  begin e.cA = 1; e.srcA = 2'b10; e.cB = 1; e.srcB = 2'b01; e.cAlu = 1; end
      K_RD:   begin e.memReq = 1; e.cAdr = 1; e.adrSrc = 1; end
      K_MWB:  begin e.cRes = 1; e.res = 2'b01; e.regWrite = 1; end
      K_WR:   begin e.memReq = 1; e.memWrite = 1; e.cAdr = 1; e.adrSrc = 1; end
      K_XR:   begin e.cA = 1; e.srcA = 2'b10; e.cB = 1; e.srcB = 2'b00; e.cAlu = 1;
                    e.alu = ref_alu(1'b1, cur_f3, cur_f7); end
      K_XI:   begin e.cA = 1; e.srcA = 2'b10; e.cB = 1; e.srcB = 2'b01; e.cAlu = 1;
                    e.alu = ref_alu(1'b0, cur_f3, cur_f7); end
      K_AWB:  begin e.cRes = 1; e.res = 2'b00; e.regWrite = 1; end
      K_BR:   begin e.cA = 1; e.srcA = 2'b10; e.cB = 1; e.srcB = 2'b00; e.cAlu = 1; e.alu = 4'b0001;
                    e.cRes = 1; e.res = 2'b00; e.pcWrite = z ^ cur_f3[0]; end
      K_JAL:  begin e.cA = 1; e.srcA = 2'b01; e.cB = 1; e.srcB = 2'b10; e.cAlu = 1;
                    e.cRes = 1; e.res = 2'b00; e.pcWrite = 1; end
      K_LUI:  begin e.cA = 1; e.srcA = 2'b11; e.cB = 1; e.srcB = 2'b01; e.cAlu = 1; end
      default: e.trap = 1;
    endcase
    if (last && k != K_TRAP) e.instrDone = is_mem(k) ? rdy : 1'b1;
    return e;
  endfunction

  task automatic check_step(input exp_t e);
    chk("memReq",    4'(mem_if.memReq),   4'(e.memReq));
    chk("memWrite",  4'(mem_if.memWrite), 4'(e.memWrite));
    chk("irWrite",   4'(irWrite),         4'(e.irWrite));
    chk("pcWrite",   4'(pcWrite),         4'(e.pcWrite));
    chk("regWrite",  4'(regWrite),        4'(e.regWrite));
    chk("instrDone", 4'(instrDone),       4'(e.instrDone));
    chk("trap",      4'(trap),            4'(e.trap));
    if (e.cAdr) chk("adrSrc",     4'(mem_if.adrSrc), 4'(e.adrSrc));
    if (e.cA)   chk("aluSrcA",    4'(aluSrcA),       4'(e.srcA));
    if (e.cB)   chk("aluSrcB",    4'(aluSrcB),       4'(e.srcB));
    if (e.cAlu) chk("aluControl", aluControl,        e.alu);
    if (e.cRes) chk("resultSrc",  4'(resultSrc),     4'(e.res));
    if (e.cImm) chk("immSrc",     4'(immSrc),        4'(e.imm));
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic reset_pulse();
    reset = 1'b1;
    mem_if.memReady = 1'b0;
    @(posedge clk); #1;
    chk("rst_trap",      4'(trap),            4'd0);
    chk("rst_instrDone", 4'(instrDone),       4'd0);
    chk("rst_memReq",    4'(mem_if.memReq),   4'd0);
    chk("rst_regWrite",  4'(regWrite),        4'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_memReq",  4'(mem_if.memReq), 4'd1);
    chk("post_rst_irWrite", 4'(irWrite),       4'd0);
    chk("post_rst_aluSrcB", 4'(aluSrcB),       4'b0010);
    @(posedge clk); #1;
  endtask

  // Runs one instruction; lat = DUT cycle (from FETCH, 1-based) of first instrDone.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int fstall, input int mstall, input int zsel,
                           input bit abort_wr, output int lat);
    int cyc;
    exp_t e;
    lat = -1;
    cyc = 0;
    cur_op = o; cur_f3 = f3; cur_f7 = f7;
    op = o; funct3 = f3; funct7b5 = f7;
    plan();
    for (int s = 0; s < steps.size(); s++) begin
      int k;
      int stall;
      bit done_step;
      bit last;
      logic rdy;
      logic z;
      k = steps[s];
      last = (s == steps.size() - 1);
      if (k == K_TRAP) begin
        for (int t = 0; t < 3; t++) begin
          mem_if.memReady = 1'($urandom_range(0, 1));
          zero = 1'($urandom_range(0, 1));
          #1;
          check_step(expect_step(K_TRAP, 1'b0, mem_if.memReady, zero));
          @(posedge clk); #1;
        end
        reset_pulse();
        return;
      end
      stall = (k == K_F) ? fstall : ((k == K_RD || k == K_WR) ? mstall : 0);
      done_step = 1'b0;
      while (!done_step) begin
        rdy = is_mem(k) ? (stall == 0) : 1'($urandom_range(0, 1));
        z = (zsel >= 0) ? 1'(zsel) : 1'($urandom_range(0, 1));
        mem_if.memReady = rdy;
        zero = z;
        #1;
        e = expect_step(k, last, rdy, z);
        check_step(e);
        cyc++;
        if (instrDone && lat < 0) lat = cyc;
        if (k == K_XR || k == K_XI) seen_alu = aluControl;
        if (k == K_BR) seen_pcw = pcWrite;
        if (k == K_JAL || k == K_LUI) seen_imm = immSrc;
        if (k == K_LUI) seen_srcA = aluSrcA;
        if (k == K_MWB) seen_res = resultSrc;
        if (abort_wr && k == K_WR) begin
          reset = 1'b1;
          @(posedge clk); #1;
          chk("abort_memReq",   4'(mem_if.memReq),   4'd0);
          chk("abort_memWrite", 4'(mem_if.memWrite), 4'd0);
          reset = 1'b0;
          mem_if.memReady = 1'b0;
          #1;
          chk("abort_fetch_memReq", 4'(mem_if.memReq),   4'd1);
          chk("abort_fetch_adrSrc", 4'(mem_if.adrSrc),   4'd0);
          @(posedge clk); #1;
          return;
        end
        @(posedge clk); #1;
        if (is_mem(k) && stall > 0) stall--;
        else done_step = 1'b1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [6:0] ops [11];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
            7'b0110111, 7'b0001111, 7'b1111111, 7'b1110011, 7'b0000000};
    reset = 1'b1;
    op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    mem_if.memReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_regWrite",  4'(regWrite),        4'd0);
    chk("init_instrDone", 4'(instrDone),       4'd0);
    chk("init_trap",      4'(trap),            4'd0);
    chk("init_memWrite",  4'(mem_if.memWrite), 4'd0);
    reset = 1'b0;
    #1;
    chk("init_fetch_memReq",  4'(mem_if.memReq), 4'd1);
    chk("init_fetch_aluSrcB", 4'(aluSrcB),       4'b0010);
    @(posedge clk); #1;

    // add x3,x1,x2
    run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, -1, 1'b0, lat);
    chk("add_latency", 4'(lat), 4'd4);
    chk("add_alu", seen_alu, 4'b0000);
    // lw with 3 fetch stalls and 2 read stalls
    run_instr(7'b0000011, 3'b010, 1'b0, 3, 2, -1, 1'b0, lat);
    chk("lw_latency", 4'(lat), 4'd10);
    chk("lw_resultSrc", 4'(seen_res), 4'b0001);
    // beq / bne with zero = 1
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, 1, 1'b0, lat);
    chk("beq_latency", 4'(lat), 4'd3);
    chk("beq_pcWrite", 4'(seen_pcw), 4'd1);
    run_instr(7'b1100011, 3'b001, 1'b0, 0, 0, 1, 1'b0, lat);
    chk("bne_pcWrite", 4'(seen_pcw), 4'd0);
    // jal then lui
    run_instr(7'b1101111, 3'b000, 1'b0, 0, 0, -1, 1'b0, lat);
    chk("jal_latency", 4'(lat), 4'd4);
    chk("jal_immSrc", 4'(seen_imm), 4'b0011);
    run_instr(7'b0110111, 3'b000, 1'b0, 0, 0, -1, 1'b0, lat);
    chk("lui_latency", 4'(lat), 4'd4);
    chk("lui_immSrc", 4'(seen_imm), 4'b0100);
    chk("lui_aluSrcA", 4'(seen_srcA), 4'b0011);
    // sw, sub, sra, fence
    run_instr(7'b0100011, 3'b010, 1'b0, 0, 0, -1, 1'b0, lat);
    chk("sw_latency", 4'(lat), 4'd4);
    run_instr(7'b0110011, 3'b000, 1'b1, 0, 0, -1, 1'b0, lat);
    chk("sub_alu", seen_alu, 4'b0001);
    run_instr(7'b0110011, 3'b101, 1'b1, 0, 0, -1, 1'b0, lat);
    chk("sra_alu", seen_alu, 4'b1001);
    run_instr(7'b0001111, 3'b000, 1'b0, 0, 0, -1, 1'b0, lat);
    chk("fence_latency", 4'(lat), 4'd2);
    // illegal opcode and ECALL
    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, -1, 1'b0, lat);
`ifdef MC_TRAP_EN
    chk("illegal_no_done", 4'(lat == -1), 4'd1);
`else
    chk("illegal_latency", 4'(lat), 4'd2);
`endif
    run_instr(7'b1110011, 3'b000, 1'b0, 1, 0, -1, 1'b0, lat);
`ifdef MC_TRAP_EN
    chk("ecall_no_done", 4'(lat == -1), 4'd1);
`else
    chk("ecall_latency", 4'(lat), 4'd3);
`endif
    // reset during a stalled store
    run_instr(7'b0100011, 3'b010, 1'b0, 0, 5, -1, 1'b1, lat);

    // randomized stream
    for (int i = 0; i < 250; i++) begin
      int idx;
      logic [6:0] o;
      idx = int'($urandom_range(0, 10));
      o = (idx == 10) ? 7'($urandom_range(0, 127)) : ops[idx];
      run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1,
                1'b0, lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
